// File: rtl/capture_ctrl_if.sv
// Control/status bundle between a capture controller and its host.
// The controller side (slave) takes run/trigger commands and drives the RAM write port and status.
interface capture_ctrl_if #(
   parameter int ADDR_W = 9
);
   logic              run;
   logic [ADDR_W-1:0] trig_pos;
   logic [3:0]        decimator;
   logic              triggered;
   logic              clr_cap_done;
   logic              we;
   logic              cap_en;
   logic [ADDR_W-1:0] cap_addr;
   logic [ADDR_W-1:0] trace_end;
   logic              armed;
   logic              capture_done;

   modport master (
      output run, trig_pos, decimator, triggered, clr_cap_done,
      input  we, cap_en, cap_addr, trace_end, armed, capture_done
   );

   modport slave (
      input  run, trig_pos, decimator, triggered, clr_cap_done,
      output we, cap_en, cap_addr, trace_end, armed, capture_done
   );
endinterface

// File: rtl/capture_ctrl.sv
// Circular-buffer capture controller: decimated RAM writes, pre-trigger arming,
// post-trigger countdown and a held DONE state until the host releases it.
module capture_ctrl #(
   parameter int ADDR_W = 9
) (
   input  logic           clk,
   input  logic           rst_n,
   capture_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, WRT, DONE} state_t;

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   state_t            state, state_nx;
   logic [14:0]       dec_cnt, dec_cnt_nx;
   logic [ADDR_W:0]   smpl_cnt, smpl_cnt_nx;
   logic [ADDR_W-1:0] post_cnt, post_cnt_nx;
   logic              trig_flag, trig_flag_nx;
   logic              we_q, we_nx;
   logic [ADDR_W-1:0] cap_addr, cap_addr_nx;
   logic [ADDR_W-1:0] trace_end, trace_end_nx;
   logic              armed, armed_nx;
   logic              done_q, done_nx;
   logic              trig_acc;
   logic              complete;
   logic [14:0]       term;

   // Terminal count follows the live decimator, so a change lands at the next compare.
   assign term = (15'd1 << bus.decimator) - 15'd1;

   // NOTE: every variable in this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx     = state;
      dec_cnt_nx   = dec_cnt;
      smpl_cnt_nx  = smpl_cnt;
      post_cnt_nx  = post_cnt;
      trig_flag_nx = trig_flag;
      we_nx        = 1'b0;
      cap_addr_nx  = cap_addr;
      trace_end_nx = trace_end;
      trig_acc     = 1'b0;
      complete     = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.run) begin
               state_nx     = WRT;
               dec_cnt_nx   = '0;
               smpl_cnt_nx  = '0;
               post_cnt_nx  = '0;
               trig_flag_nx = 1'b0;
               cap_addr_nx  = '0;
            end
         end
         WRT: begin
            if (we_q) begin
               cap_addr_nx = cap_addr + 1'b1;
               if (smpl_cnt != DEPTH) smpl_cnt_nx = smpl_cnt + 1'b1;
               if (trig_flag) post_cnt_nx = post_cnt + 1'b1;
            end
            if (dec_cnt == term) begin
               dec_cnt_nx = '0;
               we_nx      = 1'b1;
            end else begin
               dec_cnt_nx = dec_cnt + 15'd1;
            end

            trig_acc = armed && !trig_flag && bus.triggered;
            if (trig_acc) trig_flag_nx = 1'b1;

            // trig_pos=0 ends on the trigger itself, pointing at the last finished write.
            if (trig_acc && (bus.trig_pos == '0)) begin
               complete     = 1'b1;
               trace_end_nx = cap_addr - 1'b1;
            end else if (trig_flag && we_q && (post_cnt + 1'b1 == bus.trig_pos)) begin
               complete     = 1'b1;
               trace_end_nx = cap_addr;
            end

            if (!bus.run) begin
               state_nx     = IDLE;
               we_nx        = 1'b0;
               trace_end_nx = trace_end;
            end else if (complete) begin
               state_nx = DONE;
               we_nx    = 1'b0;
            end
         end
         DONE: begin
            if (bus.clr_cap_done) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign armed_nx = (state_nx == WRT) && (smpl_cnt_nx >= DEPTH - {1'b0, bus.trig_pos});
   assign done_nx  = (state_nx == DONE);

   // NOTE: state registers use non-blocking assignments and clear asynchronously on rst_n low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         dec_cnt   <= '0;
         smpl_cnt  <= '0;
         post_cnt  <= '0;
         trig_flag <= 1'b0;
         we_q      <= 1'b0;
         cap_addr  <= '0;
         trace_end <= '0;
         armed     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_nx;
         dec_cnt   <= dec_cnt_nx;
         smpl_cnt  <= smpl_cnt_nx;
         post_cnt  <= post_cnt_nx;
         trig_flag <= trig_flag_nx;
         we_q      <= we_nx;
         cap_addr  <= cap_addr_nx;
         trace_end <= trace_end_nx;
         armed     <= armed_nx;
         done_q    <= done_nx;
      end
   end

   assign bus.we           = we_q;
   assign bus.cap_en       = we_q;
   assign bus.cap_addr     = cap_addr;
   assign bus.trace_end    = trace_end;
   assign bus.armed        = armed;
   assign bus.capture_done = done_q;
endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: decimation, arming, trigger countdown, wrap,
// abort, DONE release and asynchronous reset, with hand-computed expectations.
module tb_capture_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   passed = 0;
   int   total  = 0;

   capture_ctrl_if #(.ADDR_W(9)) bus ();

   capture_ctrl #(.ADDR_W(9)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.run          = 1'b0;
      bus.trig_pos     = 9'd100;
      bus.decimator    = 4'd2;
      bus.triggered    = 1'b0;
      bus.clr_cap_done = 1'b0;

      // Reset state
      #12;
      check("rst_we",        32'(bus.we), 32'd0);
      check("rst_cap_en",    32'(bus.cap_en), 32'd0);
      check("rst_cap_addr",  32'(bus.cap_addr), 32'd0);
      check("rst_trace_end", 32'(bus.trace_end), 32'd0);
      check("rst_armed",     32'(bus.armed), 32'd0);
      check("rst_done",      32'(bus.capture_done), 32'd0);
      rst_n = 1'b1;
      step();

      // decimator=2: one write every 4 clocks, addresses 0,1,2
      bus.run = 1'b1;
      step();
      for (int k = 1; k <= 13; k++) begin
         automatic logic exp_we = (k >= 5) && (((k - 1) % 4) == 0);
         check("dec2_we", 32'(bus.we), 32'(exp_we));
         check("dec2_cap_en", 32'(bus.cap_en), 32'(exp_we));
         if (exp_we) check("dec2_addr", 32'(bus.cap_addr), 32'((k - 5) / 4));
         if (k < 13) step();
      end
      check("dec2_armed", 32'(bus.armed), 32'd0);

      // Abort by dropping run
      bus.run = 1'b0;
      step();
      check("abort_we",        32'(bus.we), 32'd0);
      check("abort_done",      32'(bus.capture_done), 32'd0);
      check("abort_armed",     32'(bus.armed), 32'd0);
      check("abort_trace_end", 32'(bus.trace_end), 32'd0);

      // decimator=0, trig_pos=256, trigger on write 300
      bus.decimator = 4'd0;
      bus.trig_pos  = 9'd256;
      bus.run       = 1'b1;
      step();
      check("d0_first_we", 32'(bus.we), 32'd0);
      repeat (256) step();
      check("d0_w256_addr",  32'(bus.cap_addr), 32'd255);
      check("d0_w256_armed", 32'(bus.armed), 32'd0);
      step();
      check("d0_armed", 32'(bus.armed), 32'd1);
      check("d0_w257_addr", 32'(bus.cap_addr), 32'd256);
      repeat (43) step();
      check("d0_trig_addr", 32'(bus.cap_addr), 32'd299);
      check("d0_trig_we",   32'(bus.we), 32'd1);
      bus.triggered = 1'b1;
      step();
      bus.triggered = 1'b0;
      check("d0_post1_addr", 32'(bus.cap_addr), 32'd300);
      repeat (255) step();
      check("d0_last_addr", 32'(bus.cap_addr), 32'd43);
      check("d0_last_done", 32'(bus.capture_done), 32'd0);
      step();
      check("d0_done",      32'(bus.capture_done), 32'd1);
      check("d0_done_we",   32'(bus.we), 32'd0);
      check("d0_done_en",   32'(bus.cap_en), 32'd0);
      check("d0_trace_end", 32'(bus.trace_end), 32'd43);
      check("d0_done_armed", 32'(bus.armed), 32'd0);
      repeat (2) step();
      check("d0_hold_done", 32'(bus.capture_done), 32'd1);
      check("d0_hold_we",   32'(bus.we), 32'd0);
      check("d0_hold_end",  32'(bus.trace_end), 32'd43);

      // clr_cap_done together with run -> IDLE, then restart at address 0
      bus.clr_cap_done = 1'b1;
      bus.trig_pos     = 9'd100;
      step();
      bus.clr_cap_done = 1'b0;
      check("clr_done", 32'(bus.capture_done), 32'd0);
      check("clr_we",   32'(bus.we), 32'd0);
      check("clr_end",  32'(bus.trace_end), 32'd43);
      step();
      check("rs_first_we", 32'(bus.we), 32'd0);
      step();
      check("rs_we",   32'(bus.we), 32'd1);
      check("rs_addr", 32'(bus.cap_addr), 32'd0);

      // Early trigger at smpl_cnt=10 is ignored; capture wraps past 512 writes
      repeat (10) step();
      check("early_armed", 32'(bus.armed), 32'd0);
      bus.triggered = 1'b1;
      step();
      bus.triggered = 1'b0;
      repeat (500) step();
      check("wrap_511_addr", 32'(bus.cap_addr), 32'd511);
      check("wrap_armed",    32'(bus.armed), 32'd1);
      step();
      check("wrap_0_addr", 32'(bus.cap_addr), 32'd0);
      check("wrap_we",     32'(bus.we), 32'd1);
      check("wrap_done",   32'(bus.capture_done), 32'd0);

      // Abort mid-WRT keeps trace_end
      bus.run = 1'b0;
      step();
      check("abort2_we",    32'(bus.we), 32'd0);
      check("abort2_armed", 32'(bus.armed), 32'd0);
      check("abort2_done",  32'(bus.capture_done), 32'd0);
      check("abort2_end",   32'(bus.trace_end), 32'd43);

      // trig_pos=0: arms after 512 writes, completes on the trigger cycle
      bus.trig_pos = 9'd0;
      bus.run      = 1'b1;
      step();
      repeat (512) step();
      check("tp0_w512_addr",  32'(bus.cap_addr), 32'd511);
      check("tp0_w512_armed", 32'(bus.armed), 32'd0);
      step();
      check("tp0_armed", 32'(bus.armed), 32'd1);
      bus.triggered = 1'b1;
      step();
      bus.triggered = 1'b0;
      check("tp0_done", 32'(bus.capture_done), 32'd1);
      check("tp0_end",  32'(bus.trace_end), 32'd511);
      check("tp0_we",   32'(bus.we), 32'd0);
      step();
      check("tp0_hold", 32'(bus.capture_done), 32'd1);

      // Asynchronous reset in DONE
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_we",        32'(bus.we), 32'd0);
      check("arst_cap_en",    32'(bus.cap_en), 32'd0);
      check("arst_cap_addr",  32'(bus.cap_addr), 32'd0);
      check("arst_trace_end", 32'(bus.trace_end), 32'd0);
      check("arst_armed",     32'(bus.armed), 32'd0);
      check("arst_done",      32'(bus.capture_done), 32'd0);
      step();
      check("arst_hold_we", 32'(bus.we), 32'd0);
      bus.run = 1'b0;
      rst_n   = 1'b1;
      step();
      check("post_rst_done", 32'(bus.capture_done), 32'd0);
      check("post_rst_we",   32'(bus.we), 32'd0);
      check("post_rst_end",  32'(bus.trace_end), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter ADDR_W, default 9, capture RAM address width; depth = 2^ADDR_W = 512 entries.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 run  in  1  level; 1 = start/continue capture, 0 = abort.
REQ-005 trig_pos  in  ADDR_W  number of post-trigger samples to write, range 0..511.
REQ-006 decimator  in  4  one sample stored every 2^decimator clocks.
REQ-007 triggered  in  1  trigger-logic event, sampled every clock.
REQ-008 clr_cap_done  in  1  command pulse that releases DONE.
REQ-009 we  out  1  registered; 1 = capture owns RAM port (write cycle).
REQ-010 cap_en  out  1  registered RAM enable; equals we.
REQ-011 cap_addr  out  ADDR_W  registered RAM write address.
REQ-012 trace_end  out  ADDR_W  registered address of the last sample written.
REQ-013 armed  out  1  registered; pre-trigger fill satisfied.
REQ-014 capture_done  out  1  registered; trace complete and stable for dump.

Function
REQ-015 States SHALL be IDLE, WRT and DONE.
REQ-016 IDLE: run=1 -> WRT next cycle; cap_addr, dec_cnt, smpl_cnt, post_cnt and trig flag cleared on that transition.
REQ-017 WRT: dec_cnt (15 bits) increments every clock; on dec_cnt == 2^decimator-1 it clears, and we=cap_en=1 for exactly the next single clock.
REQ-018 decimator=0 SHALL give we=1 on every WRT clock after the first.
REQ-019 cap_addr SHALL increment by 1 on the clock after each write, wrapping 511->0.
REQ-020 smpl_cnt (10 bits) counts writes and saturates at 512.
REQ-021 armed SHALL be 1 when smpl_cnt >= 512 - trig_pos; trig_pos=0 requires 512 writes.
REQ-022 triggered SHALL be ignored unless armed=1 and the trig flag is clear; acceptance sets the trig flag.
REQ-023 A write in the same cycle as the accepted trigger SHALL NOT count toward post_cnt.
REQ-024 post_cnt SHALL increment on each write after acceptance.
REQ-025 Capture completes on the write that makes post_cnt == trig_pos; trig_pos=0 completes on the trigger cycle.
REQ-026 On completion, trace_end SHALL load the address of the last completed write, and the FSM SHALL enter DONE next cycle.
REQ-027 DONE: capture_done=1, we=cap_en=0, cap_addr and trace_end held; clr_cap_done=1 -> IDLE.
REQ-028 run=0 in WRT SHALL abort to IDLE next cycle with we=0, capture_done=0 and trace_end unchanged.
REQ-029 run is ignored in DONE; simultaneous run and clr_cap_done in DONE -> IDLE, and run is evaluated on the following cycle.
REQ-030 A decimator change mid-capture SHALL take effect at the next terminal-count compare.
REQ-031 armed SHALL be 0 outside WRT.

Reset
REQ-032 rst_n=0 SHALL immediately force state=IDLE.
REQ-033 rst_n=0 SHALL immediately clear we, cap_en, cap_addr, trace_end, armed, capture_done and all internal counters and flags.
REQ-034 Reset during WRT or DONE SHALL abandon the capture, with no write pulse after reset assertion.

Verification
REQ-035 decimator=0, trig_pos=256, run=1, triggered pulsed at the 300th write -> armed at the 256th write; 256 further writes; trace_end=(addr of the trigger-cycle write + 256) mod 512; capture_done=1.
REQ-036 decimator=2 -> we high one clock in every 4; cap_addr steps 0,1,2,... once per pulse.
REQ-037 triggered pulsed before armed (smpl_cnt=10, trig_pos=100) -> ignored, and capture continues past 512 writes with wrap 511->0.
REQ-038 trig_pos=0, trigger accepted at 512 writes -> DONE on the next cycle with trace_end=511.
REQ-039 run dropped mid-WRT, then rst_n pulsed in DONE -> IDLE with capture_done=0 and all outputs zero.
REQ-040 DONE with clr_cap_done=1 -> IDLE; a new capture restarts at cap_addr=0.
